// File: rtl/i2c_master_tx_if.sv
// Bus bundle for the I2C write engine: TX FIFO read side, SCL/SDA pins and status.
// master = engine view, slave = FIFO/pad/controller view.
interface i2c_master_tx_if #(parameter int data_size = 8);
    logic                 START;
    logic [6:0]           SLAVE_ADDR;
    logic                 READ_EMPTY;
    logic [data_size-1:0] APB_RX;
    logic                 R_ENA;
    logic                 SCL;
    logic                 SDA_OE;
    logic                 SDA_IN;
    logic                 BUSY;
    logic                 DONE;
    logic                 NACK_ERR;
    logic [7:0]           BYTE_CNT;

    modport master (
        input  START, SLAVE_ADDR, READ_EMPTY, APB_RX, SDA_IN,
        output R_ENA, SCL, SDA_OE, BUSY, DONE, NACK_ERR, BYTE_CNT
    );

    modport slave (
        output START, SLAVE_ADDR, READ_EMPTY, APB_RX, SDA_IN,
        input  R_ENA, SCL, SDA_OE, BUSY, DONE, NACK_ERR, BYTE_CNT
    );
endinterface

// File: rtl/i2c_master_tx.sv
// I2C write engine: pops TX FIFO bytes and sends START, addr+W, data bytes, STOP, checking each ACK.
// BUSY one cycle after START; bit = 4*CLK_DIV clk; pops only at an ACKed bit-end with FIFO non-empty.
module i2c_master_tx #(
    parameter int data_size = 8,
    parameter int CLK_DIV   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    i2c_master_tx_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (data_size > 8) ? $clog2(data_size) : 3;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(data_size - 1);

    typedef enum logic [2:0] {
        IDLE, GEN_START, ADDR, ADDR_ACK, DATA, DATA_ACK, GEN_STOP
    } state_t;

    state_t               state, state_nx;
    logic [DIV_W-1:0]     div_cnt;
    logic [1:0]           q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [data_size-1:0] shreg;
    logic                 nack_bit;
    logic                 done_r;
    logic                 nack_err;
    logic [7:0]           byte_cnt;

    logic tick, bit_end, accept, ack_phase, ack_sample, pop;
    logic scl_c, oe_c;

    assign tick       = (div_cnt == DIV_LAST);
    assign bit_end    = tick && (q == 2'd3);
    assign accept     = bus.START && (state == IDLE);
    assign ack_phase  = (state == ADDR_ACK) || (state == DATA_ACK);
    assign ack_sample = ack_phase && (q == 2'd2) && tick;
    // nack_bit was captured at the end of q2, so it is current by the bit-end cycle
    assign pop        = ack_phase && bit_end && !nack_bit && !bus.READ_EMPTY;

    always_comb begin
        state_nx = state;
        scl_c    = 1'b1;
        oe_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) state_nx = GEN_START;
            end
            GEN_START: begin
                scl_c = (q != 2'd3);
                oe_c  = q[1];
                if (bit_end) state_nx = ADDR;
            end
            ADDR: begin
                scl_c = (q == 2'd1) || (q == 2'd2);
                oe_c  = !shreg[data_size-1];
                if (bit_end && bit_cnt == ADDR_LAST) state_nx = ADDR_ACK;
            end
            DATA: begin
                scl_c = (q == 2'd1) || (q == 2'd2);
                oe_c  = !shreg[data_size-1];
                if (bit_end && bit_cnt == DATA_LAST) state_nx = DATA_ACK;
            end
            ADDR_ACK, DATA_ACK: begin
                scl_c = (q == 2'd1) || (q == 2'd2);
                if (bit_end) begin
                    if (nack_bit || bus.READ_EMPTY) state_nx = GEN_STOP;
                    else                            state_nx = DATA;
                end
            end
            GEN_STOP: begin
                scl_c = (q != 2'd0);
                oe_c  = !q[1];
                if (bit_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            q        <= 2'd0;
            bit_cnt  <= '0;
            shreg    <= '0;
            nack_bit <= 1'b0;
            done_r   <= 1'b0;
            nack_err <= 1'b0;
            byte_cnt <= 8'd0;
        end else begin
            state  <= state_nx;
            done_r <= (state == GEN_STOP) && bit_end;

            if (state == IDLE) begin
                div_cnt <= '0;
                q       <= 2'd0;
            end else if (tick) begin
                div_cnt <= '0;
                q       <= q + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (accept) begin
                shreg    <= data_size'({bus.SLAVE_ADDR, 1'b0}) << (data_size - 8);
                bit_cnt  <= '0;
                nack_err <= 1'b0;
                byte_cnt <= 8'd0;
            end else if (pop) begin
                shreg   <= bus.APB_RX;
                bit_cnt <= '0;
            end else if ((state == ADDR || state == DATA) && bit_end) begin
                shreg   <= {shreg[data_size-2:0], 1'b0};
                bit_cnt <= (state_nx == state) ? bit_cnt + 1'b1 : '0;
            end

            if (ack_sample) begin
                nack_bit <= bus.SDA_IN;
                if (bus.SDA_IN)              nack_err <= 1'b1;
                else if (state == DATA_ACK)  byte_cnt <= byte_cnt + 8'd1;
            end
        end
    end

    assign bus.SCL      = scl_c;
    assign bus.SDA_OE   = oe_c;
    assign bus.R_ENA    = pop;
    assign bus.BUSY     = (state != IDLE);
    assign bus.DONE     = done_r;
    assign bus.NACK_ERR = nack_err;
    assign bus.BYTE_CNT = byte_cnt;
endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: FIFO model, ACKing slave/bus decoder, and a transaction-level reference.
module tb_i2c_master_tx;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    i2c_master_tx_if #(.data_size(8)) b1 ();
    i2c_master_tx_if #(.data_size(8)) b2 ();
    i2c_master_tx_if #(.data_size(8)) b4 ();

    i2c_master_tx #(.data_size(8), .CLK_DIV(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.master));
    i2c_master_tx #(.data_size(8), .CLK_DIV(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.master));
    i2c_master_tx #(.data_size(8), .CLK_DIV(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.master));

    int         sel = 2;
    logic       start_r = 1'b0;
    logic [6:0] addr_r = 7'd0;
    logic       rd_empty = 1'b1;
    logic [7:0] rd_dat = 8'd0;
    logic       pull = 1'b0;
    logic       sda_line;

    logic m_scl, m_oe, m_rena, m_busy, m_done, m_nack;
    logic [7:0] m_bytecnt;

    assign m_scl     = (sel == 1) ? b1.SCL      : (sel == 4) ? b4.SCL      : b2.SCL;
    assign m_oe      = (sel == 1) ? b1.SDA_OE   : (sel == 4) ? b4.SDA_OE   : b2.SDA_OE;
    assign m_rena    = (sel == 1) ? b1.R_ENA    : (sel == 4) ? b4.R_ENA    : b2.R_ENA;
    assign m_busy    = (sel == 1) ? b1.BUSY     : (sel == 4) ? b4.BUSY     : b2.BUSY;
    assign m_done    = (sel == 1) ? b1.DONE     : (sel == 4) ? b4.DONE     : b2.DONE;
    assign m_nack    = (sel == 1) ? b1.NACK_ERR : (sel == 4) ? b4.NACK_ERR : b2.NACK_ERR;
    assign m_bytecnt = (sel == 1) ? b1.BYTE_CNT : (sel == 4) ? b4.BYTE_CNT : b2.BYTE_CNT;

    assign sda_line = !m_oe && !pull;

    assign b1.START = start_r && (sel == 1);
    assign b2.START = start_r && (sel == 2);
    assign b4.START = start_r && (sel == 4);
    assign b1.SLAVE_ADDR = addr_r;  assign b2.SLAVE_ADDR = addr_r;  assign b4.SLAVE_ADDR = addr_r;
    assign b1.READ_EMPTY = rd_empty; assign b2.READ_EMPTY = rd_empty; assign b4.READ_EMPTY = rd_empty;
    assign b1.APB_RX = rd_dat;      assign b2.APB_RX = rd_dat;      assign b4.APB_RX = rd_dat;
    assign b1.SDA_IN = sda_line;    assign b2.SDA_IN = sda_line;    assign b4.SDA_IN = sda_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt, stop_cnt, done_cnt, done_cyc, pop_cnt, rena_empty_err;
    int hi_cnt, hi_min, hi_max, nbits, nack_at;
    bit hi_valid, pop_pend, prev_scl, prev_sda;
    logic       obs_bits[$];
    logic [7:0] fifo_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // TX FIFO model: first-word fall-through, pop takes effect after the DUT has loaded the head
    always @(negedge clk) begin
        logic [7:0] junk;
        if (pop_pend && fifo_q.size() > 0) junk = fifo_q.pop_front();
        pop_pend = m_rena;
        if (m_rena) begin
            pop_cnt++;
            if (rd_empty) rena_empty_err++;
        end
        rd_empty = (fifo_q.size() == 0);
        rd_dat   = rd_empty ? 8'h00 : fifo_q[0];
    end

    // Bus decoder and slave: records bits on SCL rise, START/STOP, SCL-high widths; ACKs on the 9th bit
    always @(negedge clk) begin
        logic ln;
        logic junk;
        ln = !m_oe && !pull;
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_scl && prev_scl && (ln != prev_sda)) begin
            if (!ln) begin
                start_cnt++;
                nbits = 0;
            end else begin
                stop_cnt++;
                if (obs_bits.size() > 0) junk = obs_bits.pop_back();
            end
        end
        if (m_scl && !prev_scl) begin
            obs_bits.push_back(ln);
            nbits++;
            hi_cnt   = 1;
            hi_valid = 1;
        end else if (m_scl) begin
            hi_cnt++;
        end
        if (!m_scl && prev_scl) begin
            if (hi_valid) begin
                if (hi_cnt < hi_min) hi_min = hi_cnt;
                if (hi_cnt > hi_max) hi_max = hi_cnt;
            end
            hi_valid = 0;
            pull = ((nbits % 9) == 8) && ((nbits / 9) != nack_at);
        end
        prev_scl = m_scl;
        prev_sda = !m_oe && !pull;
    end

    task automatic monitor_clear();
        @(posedge clk); #1;
        done_cnt = 0; start_cnt = 0; stop_cnt = 0; pop_cnt = 0; rena_empty_err = 0;
        obs_bits.delete();
        hi_min = 1000000; hi_max = 0; hi_valid = 0; hi_cnt = 0;
        nbits = 0; pull = 0; prev_scl = 1; prev_sda = 1; pop_pend = 0;
    endtask

    task automatic load_fifo(input logic [7:0] vals[$]);
        @(posedge clk); #1;
        fifo_q = vals;
    endtask

    // One write transaction on DUT s; slave NACKs byte index na (0 = address, -1 = never)
    task automatic run_txn(input int s, input int na, input bit poke_busy, input string name);
        logic       exp_bits[$];
        logic [7:0] m[$];
        logic [7:0] b;
        int exp_pops, exp_bc, exp_cyc, t0, idx, diff;
        bit acked, exp_nerr, ok;

        m = fifo_q;
        b = {addr_r, 1'b0};
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        acked = (na != 0);
        exp_bits.push_back(!acked);
        exp_nerr = !acked;
        exp_pops = 0; exp_bc = 0; idx = 1;
        while (acked && m.size() > 0) begin
            b = m.pop_front();
            exp_pops++;
            for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
            acked = (na != idx);
            exp_bits.push_back(!acked);
            if (acked) exp_bc++;
            else       exp_nerr = 1;
            idx++;
        end
        exp_cyc = (exp_bits.size() + 2) * 4 * s;

        sel = s;
        nack_at = na;
        monitor_clear();
        @(negedge clk) start_r = 1'b1;
        @(negedge clk) start_r = 1'b0;
        t0 = cyc;

        checks++;
        if (m_busy !== 1'b1 || m_nack !== 1'b0 || m_bytecnt !== 8'd0) begin
            errors++;
            $display("FAIL %s accept: busy=%b nack=%b cnt=%0d, want busy=1 nack=0 cnt=0", name, m_busy, m_nack, m_bytecnt);
        end
        if (poke_busy) begin
            repeat (20) @(negedge clk);
            addr_r = ~addr_r;
            start_r = 1'b1;
            @(negedge clk) start_r = 1'b0;
        end
        for (int i = 0; i < exp_cyc + 200 && done_cnt == 0; i++) @(negedge clk);
        repeat (12 * s) @(negedge clk);

        ok = (obs_bits.size() == exp_bits.size());
        diff = -1;
        for (int i = 0; ok && i < exp_bits.size(); i++)
            if (obs_bits[i] !== exp_bits[i]) begin ok = 0; diff = i; end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s bits: got %0d bits, want %0d bits, first diff at %0d", name, obs_bits.size(), exp_bits.size(), diff);
        end
        checks++;
        if (done_cnt != 1 || done_cyc - t0 != exp_cyc) begin
            errors++;
            $display("FAIL %s done: got %0d pulses at +%0d clk, want 1 at +%0d", name, done_cnt, done_cyc - t0, exp_cyc);
        end
        checks++;
        if (pop_cnt != exp_pops || rena_empty_err != 0) begin
            errors++;
            $display("FAIL %s pops: got %0d (%0d while empty), want %0d (0)", name, pop_cnt, rena_empty_err, exp_pops);
        end
        checks++;
        if (m_bytecnt !== 8'(exp_bc) || m_nack !== exp_nerr || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s status: cnt=%0d nack=%b busy=%b, want cnt=%0d nack=%b busy=0", name, m_bytecnt, m_nack, m_busy, exp_bc, exp_nerr);
        end
        ok = (fifo_q.size() == m.size());
        for (int i = 0; ok && i < m.size(); i++) if (fifo_q[i] !== m[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s fifo_left: got %0d words, want %0d", name, fifo_q.size(), m.size());
        end
        checks++;
        if (start_cnt != 1 || stop_cnt != 1) begin
            errors++;
            $display("FAIL %s start_stop: got %0d/%0d, want 1/1", name, start_cnt, stop_cnt);
        end
        checks++;
        if (hi_min != 2 * s || hi_max != 2 * s) begin
            errors++;
            $display("FAIL %s scl_high: got %0d..%0d clk, want %0d", name, hi_min, hi_max, 2 * s);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 1; s <= 4; s *= 2) begin
            sel = s;
            #1;
            checks++;
            if (m_scl !== 1'b1 || m_oe !== 1'b0 || m_rena !== 1'b0 || m_busy !== 1'b0 ||
                m_done !== 1'b0 || m_nack !== 1'b0 || m_bytecnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_state div%0d: scl=%b oe=%b rena=%b busy=%b done=%b nack=%b cnt=%0d, want 1 0 0 0 0 0 0",
                         s, m_scl, m_oe, m_rena, m_busy, m_done, m_nack, m_bytecnt);
            end
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        load_fifo('{8'hA5});
        addr_r = 7'h50;
        run_txn(2, -1, 0, "single_byte");
    endtask

    task automatic test_addr_nack();
        load_fifo('{8'h3C});
        addr_r = 7'($urandom);
        run_txn(2, 0, 0, "addr_nack");
    endtask

    task automatic test_data_nack();
        load_fifo('{8'h11, 8'h22, 8'h33});
        addr_r = 7'($urandom);
        run_txn(2, 2, 0, "data_nack");
    endtask

    task automatic test_empty_fifo();
        load_fifo('{});
        addr_r = 7'($urandom);
        run_txn(2, -1, 1, "empty_busy_start");
    endtask

    task automatic test_timing();
        load_fifo('{8'($urandom), 8'($urandom)});
        run_txn(1, -1, 0, "timing_div1");
        load_fifo('{8'($urandom), 8'($urandom)});
        run_txn(4, -1, 0, "timing_div4");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] v[$];
            int nb, s, na;
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) v.push_back(8'($urandom));
            s  = 1 << $urandom_range(0, 2);
            na = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb) : -1;
            addr_r = 7'($urandom);
            load_fifo(v);
            run_txn(s, na, 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        load_fifo('{8'h11, 8'h22});
        sel = 2;
        nack_at = -1;
        monitor_clear();
        @(negedge clk) start_r = 1'b1;
        @(negedge clk) start_r = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 400 && cyc - t0 < 100; i++) @(negedge clk);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: busy=%b, want 1", m_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (m_scl !== 1'b1 || m_oe !== 1'b0 || m_busy !== 1'b0 || m_rena !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: scl=%b oe=%b busy=%b rena=%b, want 1 0 0 0", m_scl, m_oe, m_busy, m_rena);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid done: got %0d pulses, want 0", done_cnt);
        end
        reset_n = 1'b1;
        load_fifo('{});
    endtask

    initial begin
        nack_at = -1;
        test_reset();
        test_single_byte();
        test_addr_nack();
        test_data_nack();
        test_empty_fifo();
        test_timing();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
